// File: rtl/mc_controller_v2_pkg.sv
// rtl/mc_controller_v2_pkg.sv - state encodings, field codes and select constants for the multicycle controller
package mc_controller_v2_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXECR   = 4'd2,
    S_SHIFT   = 4'd3,
    S_LDR_IMM = 4'd4,
    S_STR     = 4'd5,
    S_LDR_REG = 4'd6,
    S_LDR_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_TRAP    = 4'd9
  } state_t;

  localparam logic [1:0] GRP_ALU   = 2'b00;
  localparam logic [1:0] GRP_MEM   = 2'b01;
  localparam logic [1:0] GRP_BR    = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  localparam logic [2:0] OP_ALU_MAX = 3'b100;

  localparam logic [1:0] BRM_DIRECT = 2'b00;
  localparam logic [1:0] BRM_LINK   = 2'b01;
  localparam logic [1:0] BRM_IND    = 2'b10;
  localparam logic [1:0] BRM_ILLEGAL = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_CS = 3'b011;
  localparam logic [2:0] COND_CC = 3'b100;
  localparam logic [2:0] COND_MI = 3'b101;
  localparam logic [2:0] COND_GE = 3'b110;
  localparam logic [2:0] COND_LT = 3'b111;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_RM     = 2'b01;
  localparam logic [1:0] PCSRC_LR     = 2'b10;
  localparam logic [1:0] PCSRC_TARGET = 2'b11;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_OFS  = 2'b11;

  localparam logic [2:0] SH_PASS = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic logic [2:0] alu_ctl(input logic [2:0] op);
    case (op)
      3'b000:  return 3'b000;
      3'b001:  return 3'b001;
      3'b010:  return 3'b100;
      3'b011:  return 3'b101;
      3'b100:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_v2_if.sv
// rtl/mc_controller_v2_if.sv - controller-to-datapath bundle: instruction/flags/memory handshake in, selects and enables out
interface mc_controller_v2_if #(parameter int INSTR_W = 16);
  logic [INSTR_W-1:0] Instr;
  logic [3:0]         ALUFlags;
  logic               MemReady;
  logic               TrapClr;
  logic [1:0]         PCSrc;
  logic [1:0]         RegSrc;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               PCWrite;
  logic               LRWrite;
  logic               AddrSrc;
  logic               IRWrite;
  logic               RegWrite;
  logic               ALUSrcA;
  logic               MemWrite;
  logic [2:0]         ALUControl;
  logic [2:0]         sh;
  logic               MemReq;
  logic [3:0]         Flags;
  logic               Trap;
  logic [3:0]         StateDbg;

  modport master (
    input  Instr, ALUFlags, MemReady, TrapClr,
    output PCSrc, RegSrc, ALUSrcB, ResultSrc, PCWrite, LRWrite, AddrSrc, IRWrite,
           RegWrite, ALUSrcA, MemWrite, ALUControl, sh, MemReq, Flags, Trap, StateDbg
  );

  modport slave (
    output Instr, ALUFlags, MemReady, TrapClr,
    input  PCSrc, RegSrc, ALUSrcB, ResultSrc, PCWrite, LRWrite, AddrSrc, IRWrite,
           RegWrite, ALUSrcA, MemWrite, ALUControl, sh, MemReq, Flags, Trap, StateDbg
  );
endinterface

// File: rtl/mc_controller_v2_cond_check.sv
// rtl/mc_controller_v2_cond_check.sv - branch condition evaluation from the OP field and the registered flags
module cond_check
  import mc_controller_v2_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags[FLAG_Z];
      COND_NE: taken = !flags[FLAG_Z];
      COND_CS: taken = flags[FLAG_C];
      COND_CC: taken = !flags[FLAG_C];
      COND_MI: taken = flags[FLAG_N];
      COND_GE: taken = (flags[FLAG_N] == flags[FLAG_V]);
      COND_LT: taken = (flags[FLAG_N] != flags[FLAG_V]);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller_v2.sv
// rtl/mc_controller_v2.sv - multicycle control FSM with memory wait/timeout, conditional branches and illegal-encoding trap
module mc_controller_v2
  import mc_controller_v2_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int MEM_TMO = 15,
  parameter int LR_IDX  = 7
)(
  input logic              clk,
  input logic              reset,
  mc_controller_v2_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);
  localparam logic [2:0] LR_RM    = 3'(LR_IDX);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       taken;
  logic       at_tmo;

  logic [1:0] grp;
  logic [2:0] op;
  logic [1:0] brm;
  logic [2:0] rm;

  assign grp = bus.Instr[INSTR_W-1 -: 2];
  assign op  = bus.Instr[INSTR_W-3 -: 3];
  assign brm = bus.Instr[INSTR_W-6 -: 2];
  assign rm  = bus.Instr[2:0];

  // The cycle that would push the counter to MEM_TMO is the timeout cycle itself.
  assign at_tmo = (wait_cnt == TMO_LAST);

  cond_check u_cond (
    .op    (op),
    .flags (bus.Flags),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 bus.Flags <= 4'b0000;
    else if (state == S_EXECR) bus.Flags <= bus.ALUFlags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      wait_cnt <= 8'd0;
    else if (state_next != state || bus.MemReady)   wait_cnt <= 8'd0;
    else if (bus.MemReq)                            wait_cnt <= wait_cnt + 8'd1;
  end

  always_comb begin
    state_next     = state;
    bus.PCSrc      = PCSRC_SEQ;
    bus.ALUSrcB    = SRCB_REG;
    bus.ResultSrc  = RES_NONE;
    bus.PCWrite    = 1'b0;
    bus.LRWrite    = 1'b0;
    bus.AddrSrc    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.ALUControl = 3'b000;
    bus.sh         = SH_PASS;
    bus.MemReq     = 1'b0;
    bus.Trap       = 1'b0;

    case (state)
      S_FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
        else if (at_tmo) begin
          bus.MemReq = 1'b0;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        case (grp)
          GRP_ALU:   state_next = (op > OP_ALU_MAX) ? S_TRAP : S_EXECR;
          GRP_MEM: begin
            if (!op[2])           state_next = S_STR;
            else if (op[1])       state_next = S_LDR_IMM;
            else                  state_next = S_LDR_REG;
          end
          GRP_BR:    state_next = (brm == BRM_ILLEGAL) ? S_TRAP : S_BRANCH;
          default:   state_next = S_SHIFT;
        endcase
      end
      S_EXECR: begin
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALU;
        bus.RegWrite   = 1'b1;
        bus.ALUControl = alu_ctl(op);
        state_next     = S_FETCH;
      end
      S_SHIFT: begin
        bus.sh        = op;
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
        state_next    = S_FETCH;
      end
      S_LDR_IMM: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
        state_next    = S_FETCH;
      end
      S_STR: begin
        bus.MemReq    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.AddrSrc   = 1'b1;
        bus.ALUSrcB   = SRCB_OFS;
        bus.ResultSrc = RES_ALUOUT;
        if (bus.MemReady) state_next = S_FETCH;
        else if (at_tmo) begin
          // Abandon the write outright so a dangling request cannot turn into a read.
          bus.MemReq   = 1'b0;
          bus.MemWrite = 1'b0;
          state_next   = S_TRAP;
        end
      end
      S_LDR_REG: begin
        bus.MemReq    = 1'b1;
        bus.AddrSrc   = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        if (bus.MemReady) state_next = S_LDR_WB;
        else if (at_tmo) begin
          bus.MemReq = 1'b0;
          state_next = S_TRAP;
        end
      end
      S_LDR_WB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        if (taken) begin
          bus.PCWrite = 1'b1;
          case (brm)
            BRM_DIRECT: bus.PCSrc = PCSRC_TARGET;
            BRM_LINK: begin
              bus.PCSrc   = PCSRC_TARGET;
              bus.LRWrite = 1'b1;
            end
            default:    bus.PCSrc = (rm == LR_RM) ? PCSRC_LR : PCSRC_RM;
          endcase
        end
        state_next = S_FETCH;
      end
      S_TRAP: begin
        bus.Trap = 1'b1;
        if (bus.TrapClr) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.RegSrc = 2'b00;
    if (grp == GRP_MEM && !op[2]) bus.RegSrc = 2'b10;
    else if (grp == GRP_SHIFT)    bus.RegSrc = 2'b01;
  end

  assign bus.StateDbg = state;

endmodule

// File: tb/tb_mc_controller_v2.sv
// tb/tb_mc_controller_v2.sv - directed bench for mc_controller_v2
module tb_mc_controller_v2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_controller_v2_if #(.INSTR_W(16)) bus ();

  mc_controller_v2 #(.INSTR_W(16), .MEM_TMO(15), .LR_IDX(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [15:0] instr, input int n);
    bus.Instr = instr;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset        = 1'b1;
    bus.Instr    = 16'h0000;
    bus.ALUFlags = 4'b0000;
    bus.MemReady = 1'b0;
    bus.TrapClr  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state",   16'(bus.StateDbg),  16'd0);
    chk("rst_memreq",  16'(bus.MemReq),    16'd1);
    chk("rst_flags",   16'(bus.Flags),     16'd0);
    chk("rst_srcb",    16'(bus.ALUSrcB),   16'd2);
    chk("rst_ressrc",  16'(bus.ResultSrc), 16'd2);
    chk("rst_sh",      16'(bus.sh),        16'd7);
    chk("rst_irwrite", 16'(bus.IRWrite),   16'd0);

    // Reset in the middle of a stalled store
    reset = 1'b0;
    bus.MemReady = 1'b1;
    go(16'h4000, 0);
    chk("str_fetch_ir", 16'(bus.IRWrite), 16'd1);
    go(16'h4000, 1);
    bus.MemReady = 1'b0;
    go(16'h4000, 1);
    chk("str_state",    16'(bus.StateDbg), 16'd5);
    chk("str_memwrite", 16'(bus.MemWrite), 16'd1);
    chk("str_addrsrc",  16'(bus.AddrSrc),  16'd1);
    chk("str_regsrc",   16'(bus.RegSrc),   16'd2);
    chk("str_srcb",     16'(bus.ALUSrcB),  16'd3);
    go(16'h4000, 1);
    reset = 1'b1;
    #1;
    chk("midrst_state", 16'(bus.StateDbg), 16'd0);
    chk("midrst_mw",    16'(bus.MemWrite), 16'd0);
    go(16'h4000, 1);
    reset = 1'b0;
    go(16'h4000, 1);
    chk("rel_state", 16'(bus.StateDbg), 16'd0);
    chk("rel_mw",    16'(bus.MemWrite), 16'd0);
    chk("rel_flags", 16'(bus.Flags),    16'd0);

    // ADD: FETCH, DECODE, EXECR then back to FETCH
    bus.MemReady = 1'b1;
    go(16'h0000, 0);
    chk("add_fetch_pcw", 16'(bus.PCWrite), 16'd1);
    go(16'h0000, 1);
    chk("add_dec_state", 16'(bus.StateDbg), 16'd1);
    chk("add_dec_rw",    16'(bus.RegWrite), 16'd0);
    go(16'h0000, 1);
    chk("add_ex_state",  16'(bus.StateDbg),   16'd2);
    chk("add_ex_rw",     16'(bus.RegWrite),   16'd1);
    chk("add_ex_aluc",   16'(bus.ALUControl), 16'd0);
    chk("add_ex_srca",   16'(bus.ALUSrcA),    16'd0);
    go(16'h0000, 1);
    chk("add_back_state", 16'(bus.StateDbg), 16'd0);
    chk("add_back_rw",    16'(bus.RegWrite), 16'd0);

    // SUB sets Z, then BEQ taken and BNE not taken
    bus.ALUFlags = 4'b1000;
    go(16'h0800, 2);
    chk("sub_aluc", 16'(bus.ALUControl), 16'd1);
    go(16'h0800, 1);
    chk("sub_flags", 16'(bus.Flags), 16'h8);
    bus.ALUFlags = 4'b0000;
    go(16'h8800, 2);
    chk("beq_state", 16'(bus.StateDbg), 16'd8);
    chk("beq_pcw",   16'(bus.PCWrite),  16'd1);
    chk("beq_pcsrc", 16'(bus.PCSrc),    16'd3);
    chk("beq_lrw",   16'(bus.LRWrite),  16'd0);
    go(16'h9000, 3);
    chk("bne_pcw",   16'(bus.PCWrite), 16'd0);
    chk("bne_pcsrc", 16'(bus.PCSrc),   16'd0);
    chk("bne_flags", 16'(bus.Flags),   16'h8);

    // N=1,V=0: signed conditions and indirect/link forms
    bus.ALUFlags = 4'b0100;
    go(16'h0000, 3);
    go(16'h0000, 1);
    chk("n_flags", 16'(bus.Flags), 16'h4);
    bus.ALUFlags = 4'b0000;
    go(16'hB800, 2);
    chk("blt_pcw", 16'(bus.PCWrite), 16'd1);
    go(16'hB000, 3);
    chk("bge_pcw", 16'(bus.PCWrite), 16'd0);
    go(16'h8407, 3);
    chk("bind_lr_pcsrc", 16'(bus.PCSrc),   16'd2);
    chk("bind_lr_pcw",   16'(bus.PCWrite), 16'd1);
    go(16'h8403, 3);
    chk("bind_rm_pcsrc", 16'(bus.PCSrc), 16'd1);
    go(16'h8200, 3);
    chk("bl_lrw",   16'(bus.LRWrite), 16'd1);
    chk("bl_pcsrc", 16'(bus.PCSrc),   16'd3);

    // Shift group
    go(16'hD000, 3);
    chk("sh_state",  16'(bus.StateDbg),  16'd3);
    chk("sh_sh",     16'(bus.sh),        16'd2);
    chk("sh_res",    16'(bus.ResultSrc), 16'd3);
    chk("sh_rw",     16'(bus.RegWrite),  16'd1);
    chk("sh_regsrc", 16'(bus.RegSrc),    16'd1);

    // LDR_REG with four wait cycles
    go(16'h6000, 3);
    bus.MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ldr_wait_req",   16'(bus.MemReq),   16'd1);
      chk("ldr_wait_state", 16'(bus.StateDbg), 16'd6);
      go(16'h6000, 1);
    end
    bus.MemReady = 1'b1;
    #1;
    chk("ldr_last_req", 16'(bus.MemReq), 16'd1);
    chk("ldr_regsrc",   16'(bus.RegSrc), 16'd0);
    go(16'h6000, 1);
    chk("ldrwb_state", 16'(bus.StateDbg),  16'd7);
    chk("ldrwb_rw",    16'(bus.RegWrite),  16'd1);
    chk("ldrwb_res",   16'(bus.ResultSrc), 16'd1);
    chk("ldrwb_req",   16'(bus.MemReq),    16'd0);
    go(16'h7000, 3);
    chk("ldri_state", 16'(bus.StateDbg), 16'd4);
    chk("ldri_srcb",  16'(bus.ALUSrcB),  16'd1);

    // Store: timeout cycle drops the write, MemReady in that cycle wins
    go(16'h4000, 3);
    bus.MemReady = 1'b0;
    go(16'h4000, 14);
    chk("strw_state", 16'(bus.StateDbg), 16'd5);
    chk("tmo_mw",     16'(bus.MemWrite), 16'd0);
    chk("tmo_req",    16'(bus.MemReq),   16'd0);
    bus.MemReady = 1'b1;
    #1;
    chk("win_mw",  16'(bus.MemWrite), 16'd1);
    chk("win_req", 16'(bus.MemReq),   16'd1);
    go(16'h4000, 1);
    chk("win_state", 16'(bus.StateDbg), 16'd0);

    // Fetch timeout into TRAP, hold, then clear
    bus.MemReady = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("tmo_fetch_state", 16'(bus.StateDbg), 16'd0);
      go(16'h4000, 1);
    end
    chk("trap_state", 16'(bus.StateDbg), 16'd9);
    chk("trap_trap",  16'(bus.Trap),     16'd1);
    chk("trap_req",   16'(bus.MemReq),   16'd0);
    chk("trap_flags", 16'(bus.Flags),    16'h4);
    go(16'h4000, 1);
    chk("trap_hold", 16'(bus.StateDbg), 16'd9);
    bus.TrapClr = 1'b1;
    go(16'h4000, 1);
    bus.TrapClr = 1'b0;
    chk("clr_state", 16'(bus.StateDbg), 16'd0);
    chk("clr_trap",  16'(bus.Trap),     16'd0);

    // Illegal encodings trap from DECODE
    bus.MemReady = 1'b1;
    go(16'h2800, 1);
    chk("ill_dec", 16'(bus.StateDbg), 16'd1);
    go(16'h2800, 1);
    chk("ill_op_trap", 16'(bus.StateDbg), 16'd9);
    bus.TrapClr = 1'b1;
    go(16'h8600, 1);
    bus.TrapClr = 1'b0;
    go(16'h8600, 2);
    chk("ill_brm_trap", 16'(bus.StateDbg), 16'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
